// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin write arbiter that lets NUM_REQ producers share one FIFO write
// port. A producer owns the port for a burst of up to MAX_BURST beats. The
// burst ends early when the producer drops its request. One idle cycle always
// separates two consecutive grants.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst          asynchronous active-low reset
//   req          per-producer write request
//   req_data     producer i data in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt          one-hot current owner (registered), zero when idle
//   ack          one-hot, high in the cycle the owner's beat is written
//   fifo_full    full flag from the FIFO
//   fifo_wr_en   FIFO write enable
//   fifo_data_in FIFO write data
//   busy         high while a producer holds the grant
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    // One extra bit so the count can reach MAX_BURST on the final beat.
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t                  state_reg, state_next;
    logic [IDX_W-1:0]        owner_reg, owner_next;
    logic [IDX_W-1:0]        last_owner_reg, last_owner_next;
    logic [CNT_W-1:0]        burst_cnt_reg, burst_cnt_next;
    logic [NUM_REQ-1:0]      gnt_reg, gnt_next;

    logic                    pick_found;
    logic [IDX_W-1:0]        pick_idx;
    logic [IDX_W-1:0]        cand;
    logic                    beat;
    logic                    leave;

    logic [DATA_WIDTH-1:0]   data_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Round-robin pick: first set request strictly after last_owner,
    // wrapping around, with last_owner itself considered last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_owner_reg) + k) % NUM_REQ);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            owner_reg      <= '0;
            last_owner_reg <= IDX_W'(NUM_REQ - 1);
            burst_cnt_reg  <= '0;
            gnt_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            burst_cnt_reg  <= burst_cnt_next;
            gnt_reg        <= gnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        burst_cnt_next  = burst_cnt_reg;
        gnt_next        = gnt_reg;
        leave           = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    state_next     = GRANT;
                    owner_next     = pick_idx;
                    gnt_next       = NUM_REQ'(1) << pick_idx;
                    burst_cnt_next = '0;
                end
            end
            GRANT: begin
                if (!req[owner_reg]) begin
                    leave = 1'b1;
                end else if (!fifo_full) begin
                    burst_cnt_next = burst_cnt_reg + CNT_W'(1);
                    // The beat that completes the burst is still written.
                    if (burst_cnt_reg == CNT_W'(MAX_BURST - 1)) begin
                        leave = 1'b1;
                    end
                end
                if (leave) begin
                    state_next      = IDLE;
                    last_owner_next = owner_reg;
                    gnt_next        = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs: gated by the registered state so a reset clears them at once.
    always_comb begin
        busy         = (state_reg == GRANT);
        beat         = busy & req[owner_reg] & ~fifo_full;
        fifo_wr_en   = beat;
        ack          = beat ? gnt_reg : '0;
        fifo_data_in = busy ? data_arr[owner_reg] : '0;
    end

    assign gnt = gnt_reg;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that lets NUM_REQ producers share the single write port of the team's synchronous FIFO. It grants one producer at a time for a burst of up to MAX_BURST beats and drives the FIFO's wr_en/data_in. It honours the FIFO's full flag and acknowledges each accepted beat back to the owning producer. It sits directly in front of the FIFO write side; the FIFO read side is untouched.

Parameters:
DATA_WIDTH, 8, width of each producer's data word and of fifo_data_in
NUM_REQ, 4, number of producers (2..8)
MAX_BURST, 4, maximum beats accepted per grant before forced rotation (1..16)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-producer write request; bit i held while producer i has data
req_data  input  NUM_REQ*DATA_WIDTH  producer i data in bits [i*DATA_WIDTH +: DATA_WIDTH]
gnt  output  NUM_REQ  one-hot current owner; all zero when idle
ack  output  NUM_REQ  one-hot, high in the cycle owner's beat is written; producer advances its data on it
fifo_full  input  1  full flag from FIFO
fifo_wr_en  output  1  FIFO write enable
fifo_data_in  output  DATA_WIDTH  FIFO write data
busy  output  1  high while in GRANT state

Behaviour:
- Clock and reset: one clock clk; reset rst is asynchronous and active-low. While rst=0: state=IDLE, gnt=0, ack=0, fifo_wr_en=0, fifo_data_in=0, burst_cnt=0, busy=0, last_owner=NUM_REQ-1 (requester 0 wins first).
- States: IDLE, GRANT. owner index and gnt are registered. ack, fifo_wr_en and fifo_data_in are combinational from registered state plus req/fifo_full.
- IDLE: if any req bit is set, select the first set bit searching from last_owner+1 upward, modulo NUM_REQ. Load owner, set gnt one-hot, clear burst_cnt, and go to GRANT next cycle. With req=0, stay in IDLE.
- GRANT, beat rule: beat = req[owner] & ~fifo_full. When beat=1: fifo_wr_en=1, fifo_data_in=req_data[owner], ack[owner]=1, and burst_cnt increments. Otherwise fifo_wr_en=0 and fifo_data_in holds req_data[owner]; its value is don't-care for the FIFO.
- GRANT exit on burst limit: a beat with burst_cnt==MAX_BURST-1 leaves GRANT. That final beat is written.
- GRANT exit on dropped request: req[owner]=0 leaves GRANT with no write.
- Exit action: on either exit, last_owner<=owner, gnt<=0, state<=IDLE.
- Full stall: fifo_full=1 while in GRANT stalls with no write, no ack and no count change. The grant is held with no timeout.
- Switch timing: exactly one IDLE cycle separates consecutive grants. Worst-case throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- Independence from other requesters: req of non-owners is ignored during GRANT. Changes to req_data of the owner take effect the same cycle.
- burst_cnt width: clog2(MAX_BURST)+1 bits. It never wraps, because exit occurs at MAX_BURST-1.
- Reset mid-burst forces IDLE immediately. Any beat not yet acked is not written.
- Outputs are never X after reset. gnt, ack and fifo_wr_en are mutually consistent: ack!=0 iff fifo_wr_en=1, and ack ⊆ gnt.

Test Plan:
1. Reset, then req=4'b0001 with data 0x10,0x11,… and fifo_full=0 -> gnt=0001 after 1 cycle. 4 acks on consecutive cycles with fifo_data_in 0x10..0x13. Then 1 IDLE cycle, then re-grant to requester 0.
2. req=4'b1111 held, fifo_full=0 -> grant order 0,1,2,3,0. Each owner gets exactly 4 writes. Each grant is separated by 1 idle cycle (busy low), giving 20 writes in 25 cycles.
3. Requester 2 granted; fifo_full=1 for 6 cycles after its 2nd beat -> no wr_en or ack during the stall and gnt stays 0100. After full drops, exactly 2 more beats complete, then release.
4. Requester 1 granted; it drops req after 1 beat -> release next edge with burst_cnt=1. The next grant searches from requester 2, so req=4'b0011 grants requester 0.
5. Assert rst=0 mid-burst (after 2 beats) -> gnt, ack and fifo_wr_en are 0 asynchronously. After release, requester 0 is granted first.
6. Scoreboard with a FIFO model: random req/data/full for 2000 cycles -> every ack corresponds to exactly one write. Data order per producer is preserved, and no write occurs while fifo_full=1.
